// File: rtl/volt_pkg.sv
// volt_pkg
// Shared definitions for the voltage-to-code converter.
// Contents:
//   DEFAULT_FULL_SCALE / DEFAULT_SHIFT - scaling defaults (0.1 mV units, log2 code range)
//   ASCII_PLUS / ASCII_MINUS           - accepted sign characters
//   CODE_W                             - width of the AD-format code
//   state_t                            - converter FSM states
//   digits_legal / bcd_value           - helpers for checking a request on arrival
package volt_pkg;

   localparam int unsigned DEFAULT_FULL_SCALE = 50000;
   localparam int unsigned DEFAULT_SHIFT      = 15;

   localparam logic [7:0] ASCII_PLUS  = 8'd43;
   localparam logic [7:0] ASCII_MINUS = 8'd45;

   localparam int CODE_W = 18;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BCD  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   // True when every nibble of the five-digit BCD word is 0..9.
   function automatic logic digits_legal(input logic [19:0] d);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (d[4*i +: 4] > 4'd9) begin
            ok = 1'b0;
         end
      end
      return ok;
   endfunction

   // Binary value of the BCD word. The result is 20 bits wide so that words
   // containing illegal digits still compare as "too large" without wrapping.
   function automatic logic [19:0] bcd_value(input logic [19:0] d);
      logic [19:0] acc;
      acc = '0;
      for (int i = 4; i >= 0; i--) begin
         acc = 20'(acc * 20'd10) + 20'(d[4*i +: 4]);
      end
      return acc;
   endfunction

endpackage

// File: rtl/udiv31_serial.sv
// udiv31_serial
// Serial restoring divider, one quotient bit per clock, MSB first.
// The first bit is resolved on the same edge that loads the operands, so a
// W-bit quotient is complete W-1 edges after start, flagged by a one-cycle
// done pulse; quotient then holds until the next start.
// Ports:
//   clk       system clock
//   ad_reset  synchronous active-high reset, clears remainder and quotient
//   start     load dividend/divisor and begin a division
//   dividend  W-bit unsigned dividend
//   divisor   W-bit unsigned divisor (non-zero)
//   done      one-cycle pulse when quotient is valid
//   quotient  W-bit unsigned quotient
module udiv31_serial #(
   parameter int W = 31
) (
   input  logic         clk,
   input  logic         ad_reset,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         done,
   output logic [W-1:0] quotient
);

   logic [W-1:0] rem;
   logic [W-1:0] dq;
   logic [4:0]   cnt;
   logic         busy;
   logic         done_q;

   logic         bit_in;
   logic [W-1:0] rem_in;
   logic [W:0]   shifted;
   logic [W:0]   diff;
   logic         q_bit;
   logic [W-1:0] rem_step;
   logic [W-2:0] low_src;

   // One restoring step. On start the step works straight from the new
   // dividend with a zero remainder; otherwise it continues from the
   // registers. dq shifts the dividend out at the top while quotient bits
   // enter at the bottom.
   always_comb begin
      bit_in   = start ? dividend[W-1] : dq[W-1];
      rem_in   = start ? '0 : rem;
      low_src  = start ? dividend[W-2:0] : dq[W-2:0];
      shifted  = {rem_in, bit_in};
      diff     = shifted - {1'b0, divisor};
      q_bit    = (shifted >= {1'b0, divisor});
      rem_step = q_bit ? diff[W-1:0] : shifted[W-1:0];
   end

   // Iteration state: remainder, shift register and bit counter.
   always_ff @(posedge clk) begin
      if (ad_reset) begin
         rem    <= '0;
         dq     <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            rem  <= rem_step;
            dq   <= {low_src, q_bit};
            cnt  <= 5'd1;
            busy <= 1'b1;
         end else if (busy) begin
            rem <= rem_step;
            dq  <= {low_src, q_bit};
            cnt <= 5'(cnt + 5'd1);
            if (cnt == 5'(W - 1)) begin
               busy   <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done     = done_q;
   assign quotient = dq;

endmodule

// File: rtl/volt_to_code.sv
// volt_to_code
// Converts a signed five-digit BCD voltage (0.1 mV units) into an 18-bit
// AD-format code. Positive values give the rounded magnitude
// round(v * 2^SHIFT / FULL_SCALE); negative values give its 18-bit complement.
// A valid request produces its result 36 cycles after acceptance; a malformed
// one (illegal digit, above full scale, unknown sign) is flagged with err one
// cycle after acceptance.
// Ports:
//   clk        system clock
//   ad_reset   synchronous active-high reset
//   in_valid   request present
//   in_ready   block idle, can accept a request
//   dec        five BCD digits, dec[19:16] most significant
//   sig        ASCII sign, '+' or '-'
//   out_valid  result present
//   out_ready  consumer takes the result
//   code       AD-format code
//   err        request rejected
module volt_to_code
   import volt_pkg::*;
#(
   parameter int unsigned FULL_SCALE = DEFAULT_FULL_SCALE,
   parameter int unsigned SHIFT      = DEFAULT_SHIFT
) (
   input  logic              clk,
   input  logic              ad_reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [19:0]       dec,
   input  logic [7:0]        sig,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CODE_W-1:0] code,
   output logic              err
);

   localparam logic [30:0] DIVISOR   = 31'(FULL_SCALE);
   localparam logic [30:0] HALF      = 31'(FULL_SCALE / 2);
   localparam logic [30:0] MAG_LIMIT = 31'(1) << SHIFT;

   state_t state;
   state_t state_next;

   logic [19:0]       dec_q;
   logic [7:0]        sig_q;
   logic              reject_q;
   logic [16:0]       bin;
   logic [2:0]        digit_cnt;
   logic [CODE_W-1:0] code_q;
   logic              err_q;
   logic              out_valid_q;

   logic              accept;
   logic              request_ok;
   logic [3:0]        digit;
   logic [16:0]       bin_next;
   logic              div_start;
   logic [30:0]       div_dividend;
   logic              div_done;
   logic [30:0]       div_quotient;
   logic [CODE_W-1:0] mag;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid && in_ready;

   // A request is checked on the incoming port values at the accept edge so
   // that a bad one can skip straight to DONE after a single cycle.
   assign request_ok = digits_legal(dec)
                    && (bcd_value(dec) <= 20'(FULL_SCALE))
                    && ((sig == ASCII_PLUS) || (sig == ASCII_MINUS));

   // The last BCD cycle hands bin_next directly to the divider so the
   // division starts on the same edge that absorbs the final digit.
   assign div_dividend = (31'(bin_next) << SHIFT) + HALF;

   // The quotient cannot exceed 2^SHIFT for in-range inputs; the clamp keeps
   // the code inside the legal magnitude range regardless.
   assign mag = (div_quotient > MAG_LIMIT) ? CODE_W'(MAG_LIMIT)
                                           : div_quotient[CODE_W-1:0];

   udiv31_serial #(
      .W(31)
   ) u_div (
      .clk      (clk),
      .ad_reset (ad_reset),
      .start    (div_start),
      .dividend (div_dividend),
      .divisor  (DIVISOR),
      .done     (div_done),
      .quotient (div_quotient)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (ad_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic plus the digit selector and divider kick-off. Digits
   // are consumed most significant first, one per BCD cycle.
   always_comb begin
      state_next = state;
      div_start  = 1'b0;
      case (digit_cnt)
         3'd0:    digit = dec_q[19:16];
         3'd1:    digit = dec_q[15:12];
         3'd2:    digit = dec_q[11:8];
         3'd3:    digit = dec_q[7:4];
         default: digit = dec_q[3:0];
      endcase
      bin_next = 17'(bin * 17'd10) + 17'(digit);
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = BCD;
            end
         end
         BCD: begin
            if (reject_q) begin
               state_next = DONE;
            end else if (digit_cnt == 3'd4) begin
               state_next = DIV;
               div_start  = 1'b1;
            end
         end
         DIV: begin
            if (div_done) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: captures the request, accumulates the binary value, and
   // registers the result. Results hold until the consumer takes them.
   always_ff @(posedge clk) begin
      if (ad_reset) begin
         dec_q       <= '0;
         sig_q       <= '0;
         reject_q    <= 1'b0;
         bin         <= '0;
         digit_cnt   <= '0;
         code_q      <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  dec_q     <= dec;
                  sig_q     <= sig;
                  reject_q  <= !request_ok;
                  bin       <= '0;
                  digit_cnt <= '0;
               end
            end
            BCD: begin
               if (reject_q) begin
                  code_q      <= '0;
                  err_q       <= 1'b1;
                  out_valid_q <= 1'b1;
               end else begin
                  bin       <= bin_next;
                  digit_cnt <= 3'(digit_cnt + 3'd1);
               end
            end
            DIV: begin
               if (div_done) begin
                  code_q      <= (sig_q == ASCII_MINUS) ? ~mag : mag;
                  err_q       <= 1'b0;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign code      = code_q;
   assign err       = err_q;

endmodule
